// File: rtl/tetris_pkg.sv
// tetris_pkg: shared piece types, spawn position and LFSR taps for the game_clk domain
package tetris_pkg;
  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_type_t;
  localparam logic [4:0] SPAWN_ROW = 5'd0;
  localparam logic [3:0] SPAWN_COL = 4'd3;
  // right-shifting Galois form of x^16+x^14+x^13+x^11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef struct packed {
    piece_type_t ptype;
    logic [1:0]  rotation;
    logic [4:0]  row;
    logic [3:0]  col;
  } active_piece_t;
endpackage

// File: rtl/bag_draw.sv
// bag_draw: picks the next bag piece from random bits and the used-type mask
//   mask_i  types already drawn in the current bag
//   rnd_i   low random bits (7 folds onto 0)
//   piece_o drawn type: first clear type at or above rnd_i, wrapping mod 7
//   mask_o  mask after the draw, cleared to 0 once the bag completes
module bag_draw
  import tetris_pkg::*;
(
  input  logic [6:0]  mask_i,
  input  logic [2:0]  rnd_i,
  output piece_type_t piece_o,
  output logic [6:0]  mask_o
);
  logic [2:0] start, sel;
  logic [3:0] cand;
  logic       found;
  logic [6:0] set_mask;
  always_comb begin
    start = (rnd_i == 3'd7) ? 3'd0 : rnd_i;
    sel   = start;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < 7; k++) begin
      cand = {1'b0, start} + 4'(k);
      cand = (cand >= 4'd7) ? cand - 4'd7 : cand;
      if (!found && !mask_i[cand[2:0]]) begin
        sel   = cand[2:0];
        found = 1'b1;
      end
    end
    set_mask = mask_i | (7'd1 << sel);
    mask_o   = (set_mask == 7'h7F) ? 7'd0 : set_mask;
    piece_o  = piece_type_t'(sel);
  end
endmodule

// File: rtl/piece_bag_generator.sv
// piece_bag_generator: 7-bag tetromino source with preview queue for game_executioner
//   game_clk    clock
//   reset       asynchronous active-low reset
//   piece_req   pop request (executioner insert strobe)
//   seed_load   load seed_value (zero substitutes DEFAULT_SEED)
//   seed_value  new LFSR seed
//   new_piece   queue head at spawn position
//   piece_valid queue head holds a drawn piece
//   preview     queue entries 1..PREVIEW_DEPTH
//   req_dropped sticky: request seen while the head was empty
module piece_bag_generator
  import tetris_pkg::*;
#(
  parameter int                    PREVIEW_DEPTH = 3,
  parameter int                    LFSR_WIDTH    = 16,
  parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED  = 16'hACE1
) (
  input  logic                                game_clk,
  input  logic                                reset,
  input  logic                                piece_req,
  input  logic                                seed_load,
  input  logic [LFSR_WIDTH-1:0]               seed_value,
  output active_piece_t                       new_piece,
  output logic                                piece_valid,
  output piece_type_t [PREVIEW_DEPTH-1:0]     preview,
  output logic                                req_dropped
);
  localparam int QD = PREVIEW_DEPTH + 1;
  localparam int CW = $clog2(QD + 1);
  typedef enum logic {FILL, FULL} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d, ins;
  logic [QD-1:0][2:0]    q_q, q_d;
  logic [6:0]            mask_q, mask_d, draw_mask;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic                  req_dropped_q, req_dropped_d, pop, draw;
  piece_type_t           drawn;
  bag_draw u_draw (
    .mask_i  (mask_q),
    .rnd_i   (lfsr_q[2:0]),
    .piece_o (drawn),
    .mask_o  (draw_mask)
  );
  assign piece_valid = (count_q != '0);
  // a pop always refills the freed tail slot, so count only grows while filling
  always_comb begin
    pop     = piece_req && piece_valid;
    draw    = pop || (state_q == FILL);
    ins     = pop ? count_q - CW'(1) : count_q;
    q_d     = pop ? {3'd0, q_q[QD-1:1]} : q_q;
    for (int i = 0; i < QD; i++)
      if (draw && CW'(i) == ins) q_d[i] = drawn;
    count_d = pop ? count_q : count_q + CW'(draw);
    state_d = (count_d == CW'(QD)) ? FULL : FILL;
    mask_d  = draw ? draw_mask : mask_q;
    lfsr_d  = seed_load ? ((seed_value == '0) ? DEFAULT_SEED : seed_value)
                        : ({1'b0, lfsr_q[LFSR_WIDTH-1:1]} ^ (lfsr_q[0] ? LFSR_WIDTH'(LFSR_TAPS) : '0));
    req_dropped_d = req_dropped_q || (piece_req && !piece_valid);
  end
  always_ff @(posedge game_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FILL;
      count_q       <= '0;
      q_q           <= '0;
      mask_q        <= '0;
      lfsr_q        <= DEFAULT_SEED;
      req_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      q_q           <= q_d;
      mask_q        <= mask_d;
      lfsr_q        <= lfsr_d;
      req_dropped_q <= req_dropped_d;
    end
  end
  assign new_piece = '{ptype: piece_type_t'(q_q[0]), rotation: 2'd0, row: SPAWN_ROW, col: SPAWN_COL};
  for (genvar p = 0; p < PREVIEW_DEPTH; p++) begin : g_prev
    assign preview[p] = piece_type_t'(q_q[p+1]);
  end
  assign req_dropped = req_dropped_q;
endmodule

// File: tb/tb_piece_bag_generator.sv
// tb_piece_bag_generator: directed checks of fill, bag permutation, seeding, draw rules and error flag
module tb_piece_bag_generator;
  import tetris_pkg::*;
  logic            game_clk = 1'b0;
  logic            reset = 1'b0;
  logic            piece_req = 1'b0;
  logic            seed_load = 1'b0;
  logic [15:0]     seed_value = 16'd0;
  active_piece_t   new_piece;
  logic            piece_valid;
  logic            req_dropped;
  piece_type_t [2:0] preview;
  logic [6:0]      d_mask, d_mask_o;
  logic [2:0]      d_rnd;
  piece_type_t     d_piece;
  int              vectors = 0;
  int              miscompares = 0;
  piece_type_t     cap[21];
  piece_type_t     seq_a[21];
  piece_type_t     seq_b[21];

  piece_bag_generator #(.PREVIEW_DEPTH(3), .LFSR_WIDTH(16), .DEFAULT_SEED(16'hACE1)) dut (
    .game_clk    (game_clk),
    .reset       (reset),
    .piece_req   (piece_req),
    .seed_load   (seed_load),
    .seed_value  (seed_value),
    .new_piece   (new_piece),
    .piece_valid (piece_valid),
    .preview     (preview),
    .req_dropped (req_dropped)
  );

  bag_draw u_bd (
    .mask_i  (d_mask),
    .rnd_i   (d_rnd),
    .piece_o (d_piece),
    .mask_o  (d_mask_o)
  );

  always #5 game_clk = ~game_clk;

  // pulse reset, release on a falling edge with the given seed/request, return one edge later
  task automatic restart(input logic ld, input logic [15:0] s, input logic rq);
    @(negedge game_clk);
    reset = 1'b0; piece_req = 1'b0; seed_load = 1'b0;
    @(negedge game_clk);
    reset = 1'b1; seed_load = ld; seed_value = s; piece_req = rq;
    @(negedge game_clk);
    seed_load = 1'b0; piece_req = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (piece_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", piece_valid); end
    vectors++;
    if (req_dropped !== 1'b0) begin miscompares++; $display("FAIL reset_dropped: got %0b expected 0", req_dropped); end
    vectors++;
    if (new_piece.ptype !== PIECE_I) begin miscompares++; $display("FAIL reset_head: got %0d expected %0d", new_piece.ptype, PIECE_I); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (preview[i] !== PIECE_I) begin miscompares++; $display("FAIL reset_preview%0d: got %0d expected 0", i, preview[i]); end
    end
  endtask

  // ACE1 -> E270 -> 7138 -> 389C gives idx 1,0,0,4 -> O, I, T (0,1 used), Z
  task automatic test_fill();
    piece_type_t exp_prev[3];
    exp_prev = '{PIECE_I, PIECE_T, PIECE_Z};
    @(negedge game_clk);
    reset = 1'b1;
    @(negedge game_clk);
    vectors++;
    if (piece_valid !== 1'b1) begin miscompares++; $display("FAIL fill_valid_1edge: got %0b expected 1", piece_valid); end
    vectors++;
    if (new_piece.ptype !== PIECE_O) begin miscompares++; $display("FAIL fill_head_1edge: got %0d expected %0d", new_piece.ptype, PIECE_O); end
    vectors++;
    if (preview[0] !== PIECE_I) begin miscompares++; $display("FAIL fill_prev0_1edge: got %0d expected 0", preview[0]); end
    repeat (3) @(negedge game_clk);
    vectors++;
    if (new_piece.ptype !== PIECE_O) begin miscompares++; $display("FAIL fill_head: got %0d expected %0d", new_piece.ptype, PIECE_O); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (preview[i] !== exp_prev[i]) begin miscompares++; $display("FAIL fill_prev%0d: got %0d expected %0d", i, preview[i], exp_prev[i]); end
    end
    vectors++;
    if (new_piece.rotation !== 2'd0) begin miscompares++; $display("FAIL spawn_rot: got %0d expected 0", new_piece.rotation); end
    vectors++;
    if (new_piece.row !== 5'd0) begin miscompares++; $display("FAIL spawn_row: got %0d expected 0", new_piece.row); end
    vectors++;
    if (new_piece.col !== 4'd3) begin miscompares++; $display("FAIL spawn_col: got %0d expected 3", new_piece.col); end
    @(negedge game_clk);
    vectors++;
    if (preview[2] !== PIECE_Z || new_piece.ptype !== PIECE_O) begin
      miscompares++; $display("FAIL full_hold: got head %0d tail %0d expected 1 4", new_piece.ptype, preview[2]);
    end
  endtask

  task automatic test_back_to_back();
    piece_type_t got[14];
    piece_type_t first[4];
    logic [6:0] bits;
    first = '{PIECE_O, PIECE_I, PIECE_T, PIECE_Z};
    piece_req = 1'b1;
    for (int k = 0; k < 14; k++) begin
      got[k] = new_piece.ptype;
      vectors++;
      if (piece_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid%0d: got %0b expected 1", k, piece_valid); end
      @(negedge game_clk);
    end
    piece_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (got[k] !== first[k]) begin miscompares++; $display("FAIL b2b_order%0d: got %0d expected %0d", k, got[k], first[k]); end
    end
    for (int g = 0; g < 2; g++) begin
      bits = '0;
      for (int j = 0; j < 7; j++) bits = bits | (7'd1 << got[g*7+j]);
      vectors++;
      if (bits !== 7'h7F) begin miscompares++; $display("FAIL b2b_bag%0d: got %h expected 7f", g, bits); end
    end
    vectors++;
    if (piece_valid !== 1'b1 || req_dropped !== 1'b0) begin
      miscompares++; $display("FAIL b2b_after: got valid %0b dropped %0b expected 1 0", piece_valid, req_dropped);
    end
  endtask

  task automatic run_seq(input logic [15:0] s);
    restart(1'b1, s, 1'b0);
    repeat (3) @(negedge game_clk);
    piece_req = 1'b1;
    for (int k = 0; k < 21; k++) begin
      cap[k] = new_piece.ptype;
      @(negedge game_clk);
    end
    piece_req = 1'b0;
  endtask

  task automatic test_seed();
    logic [6:0] bits;
    run_seq(16'h1234);
    seq_a = cap;
    run_seq(16'h1234);
    seq_b = cap;
    for (int k = 0; k < 21; k++) begin
      vectors++;
      if (seq_a[k] !== seq_b[k]) begin miscompares++; $display("FAIL seed_repeat%0d: got %0d expected %0d", k, seq_b[k], seq_a[k]); end
    end
    for (int g = 0; g < 3; g++) begin
      bits = '0;
      for (int j = 0; j < 7; j++) bits = bits | (7'd1 << seq_a[g*7+j]);
      vectors++;
      if (bits !== 7'h7F) begin miscompares++; $display("FAIL seed_bag%0d: got %h expected 7f", g, bits); end
    end
    run_seq(16'h0000);
    seq_a = cap;
    run_seq(16'hACE1);
    seq_b = cap;
    for (int k = 0; k < 21; k++) begin
      vectors++;
      if (seq_a[k] !== seq_b[k]) begin miscompares++; $display("FAIL seed_zero%0d: got %0d expected %0d", k, seq_a[k], seq_b[k]); end
    end
  endtask

  task automatic test_draw();
    logic [6:0]  vm[5];
    logic [2:0]  vr[5];
    piece_type_t vp[5];
    logic [6:0]  vo[5];
    vm = '{7'b0000001, 7'b0111111, 7'b0000000, 7'b1000000, 7'b1111110};
    vr = '{3'd7,       3'd7,       3'd3,       3'd6,       3'd5};
    vp = '{PIECE_O,    PIECE_L,    PIECE_S,    PIECE_I,    PIECE_I};
    vo = '{7'b0000011, 7'b0000000, 7'b0001000, 7'b1000001, 7'b0000000};
    for (int v = 0; v < 5; v++) begin
      d_mask = vm[v]; d_rnd = vr[v];
      #1;
      vectors++;
      if (d_piece !== vp[v]) begin miscompares++; $display("FAIL draw_type%0d: got %0d expected %0d", v, d_piece, vp[v]); end
      vectors++;
      if (d_mask_o !== vo[v]) begin miscompares++; $display("FAIL draw_mask%0d: got %b expected %b", v, d_mask_o, vo[v]); end
    end
  endtask

  task automatic test_req_dropped();
    restart(1'b0, 16'd0, 1'b1);
    vectors++;
    if (req_dropped !== 1'b1) begin miscompares++; $display("FAIL drop_set: got %0b expected 1", req_dropped); end
    vectors++;
    if (new_piece.ptype !== PIECE_O || piece_valid !== 1'b1) begin
      miscompares++; $display("FAIL drop_head: got %0d valid %0b expected 1 1", new_piece.ptype, piece_valid);
    end
    repeat (3) @(negedge game_clk);
    vectors++;
    if (new_piece.ptype !== PIECE_O || preview[0] !== PIECE_I || preview[1] !== PIECE_T || preview[2] !== PIECE_Z) begin
      miscompares++; $display("FAIL drop_noshift: got %0d %0d %0d %0d expected 1 0 2 4", new_piece.ptype, preview[0], preview[1], preview[2]);
    end
    piece_req = 1'b1;
    @(negedge game_clk);
    piece_req = 1'b0;
    vectors++;
    if (new_piece.ptype !== PIECE_I) begin miscompares++; $display("FAIL drop_pop: got %0d expected 0", new_piece.ptype); end
    repeat (2) @(negedge game_clk);
    vectors++;
    if (req_dropped !== 1'b1) begin miscompares++; $display("FAIL drop_sticky: got %0b expected 1", req_dropped); end
    reset = 1'b0;
    #1;
    vectors++;
    if (req_dropped !== 1'b0) begin miscompares++; $display("FAIL drop_clear: got %0b expected 0", req_dropped); end
  endtask

  task automatic test_reset_mid_burst();
    logic [6:0] bits;
    piece_type_t first;
    restart(1'b0, 16'd0, 1'b0);
    repeat (3) @(negedge game_clk);
    piece_req = 1'b1;
    repeat (2) @(negedge game_clk);
    vectors++;
    if (new_piece.ptype !== PIECE_T) begin miscompares++; $display("FAIL burst_head: got %0d expected 2", new_piece.ptype); end
    reset = 1'b0;
    #1;
    piece_req = 1'b0;
    vectors++;
    if (piece_valid !== 1'b0 || new_piece.ptype !== PIECE_I || req_dropped !== 1'b0) begin
      miscompares++; $display("FAIL burst_reset: got valid %0b head %0d dropped %0b expected 0 0 0", piece_valid, new_piece.ptype, req_dropped);
    end
    vectors++;
    if (preview[0] !== PIECE_I || preview[1] !== PIECE_I || preview[2] !== PIECE_I) begin
      miscompares++; $display("FAIL burst_reset_prev: got %0d %0d %0d expected 0 0 0", preview[0], preview[1], preview[2]);
    end
    @(negedge game_clk);
    reset = 1'b1;
    @(negedge game_clk);
    vectors++;
    if (new_piece.ptype !== PIECE_O || piece_valid !== 1'b1) begin
      miscompares++; $display("FAIL burst_refill: got %0d valid %0b expected 1 1", new_piece.ptype, piece_valid);
    end
    repeat (3) @(negedge game_clk);
    piece_req = 1'b1;
    bits = '0;
    first = new_piece.ptype;
    for (int k = 0; k < 7; k++) begin
      bits = bits | (7'd1 << new_piece.ptype);
      @(negedge game_clk);
    end
    piece_req = 1'b0;
    vectors++;
    if (first !== PIECE_O) begin miscompares++; $display("FAIL burst_first: got %0d expected 1", first); end
    vectors++;
    if (bits !== 7'h7F) begin miscompares++; $display("FAIL burst_bag: got %h expected 7f", bits); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_seed();
    test_draw();
    test_req_dropped();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
